int_to_float_conv: RTL and testbench
====================================

Name: int_to_float_conv

Overview:
- Multi-cycle converter from a parametrised-width integer to an IEEE754-style binary float with configurable exponent and mantissa widths.
- Successor to the fixed 16-bit half-precision converter. Adds:
  - runtime signed/unsigned selection
  - round-to-nearest-even or truncation
  - overflow saturation to infinity and an inexact flag
  - valid/ready handshakes on both sides
- Sits between the integer datapath and float consumers; one conversion in flight at a time.

Parameters:
- IN_W, 16, integer input width (≥2).
- EXP_W, 5, exponent field width; BIAS = 2^(EXP_W-1)-1.
- MAN_W, 10, stored mantissa (fraction) width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input word offered.
- in_ready  out  1  converter can accept; high only in IDLE.
- in_data  in  IN_W  integer operand.
- in_signed  in  1  1 = in_data is two's complement; 0 = unsigned. Sampled with in_data.
- rnd_mode  in  1  0 = truncate toward zero, 1 = round-nearest-even. Sampled with in_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_data  out  1+EXP_W+MAN_W  {sign, biased exponent, fraction}.
- out_overflow  out  1  result saturated to ±infinity.
- out_inexact  out  1  result not exactly equal to the input.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; out_valid=0; out_data=0; out_overflow=0; out_inexact=0; all internal registers 0.
- States: IDLE, ABS, NORM, ROUND, PACK, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data, in_signed, rnd_mode; → ABS.
  - in_ready drops the next cycle.
- ABS:
  - sign = in_signed & in_data[IN_W-1].
  - mag = sign ? two's-complement negation : in_data, held in an IN_W-bit unsigned register. Most-negative input gives mag = 2^(IN_W-1), which is correct as unsigned.
  - mag==0 → PACK with zero result. Otherwise k=0, → NORM.
- NORM:
  - One comparison per cycle.
  - mag[IN_W-1]==1 → ROUND.
  - Otherwise mag<<=1, k+=1, stay.
  - Occupies k+1 cycles, where k = leading zeros of the magnitude (0..IN_W-1).
- ROUND:
  - Unbiased exponent e = IN_W-1-k.
  - frac = mag[IN_W-2 -: MAN_W], zero-filled on the right if MAN_W > IN_W-1.
  - G = first dropped bit; S = OR of the remaining dropped bits; inexact = G|S.
  - rnd_mode=1: increment frac if G&(S|frac[0]). Fraction carry-out → frac=0, e+=1.
  - rnd_mode=0: no increment.
  - Biased exponent E = e+BIAS, width EXP_W+1.
  - If E ≥ 2^EXP_W-1: result = {sign, all-ones, 0}, overflow=1, inexact=1.
- PACK: drive out_data/flags; out_valid ← 1; → HOLD.
  - Zero result: out_data=0 (sign forced 0), flags 0.
- HOLD:
  - out_valid=1; out_data and flags stable.
  - On out_ready: out_valid ← 0, → IDLE. in_ready is high the following cycle.
  - out_ready low holds indefinitely.
- Latency from the accepting edge to out_valid high:
  - nonzero: k+4 edges.
  - zero: 2 edges.
- Throughput: one result per (latency + handshake) cycles; no overlap.
- in_valid while busy is ignored; the sender must hold it until in_ready.
- out_ready outside HOLD has no effect.
- All arithmetic is unsigned except sign extraction. Exponent and k counters are sized with $clog2(IN_W)+1 bits minimum.

Decomposition:
- Shared package float_conv_pkg holds:
  - state enum
  - rounding-mode constants (RND_TRUNC=0, RND_RNE=1)
  - BIAS and field-width helper functions
- Optional sub-module fp_round_pack: combinational rounding, exponent carry, overflow saturation and field packing. Takes sign, normalised mag, k and rnd_mode; returns out_data and flags. Reusable by future float converters.

Test Plan (defaults IN_W=16, EXP_W=5, MAN_W=10):
- in_data=1, unsigned, RNE → out_data=0x3C00, flags 0, out_valid 19 edges after accept (k=15).
- in_data=0xFFFF, signed → 0xBC00 (−1). in_data=0x8000, signed → 0xF800 (−32768), exact.
- 2049 RNE → 0x6800, inexact=1 (tie to even). 2051 RNE → 0x6802, inexact=1. 2051 truncate → 0x6801, inexact=1.
- 0xFFFF unsigned: RNE → 0x7C00, overflow=1, inexact=1; truncate → 0x7BFF, overflow=0, inexact=1.
- in_data=0 → 0x0000 two edges after accept. Hold out_ready=0 for 10 cycles → out_valid/out_data stable, in_ready=0. Release out_ready → IDLE, in_ready=1 next cycle.
- Assert reset mid-NORM → out_valid=0, in_ready=1 immediately. A new conversion after release completes correctly.

Source files
------------

// File: rtl/float_conv_pkg.sv
// Shared definitions for integer-to-float converters: FSM states, rounding modes
// and field-width helpers.
package float_conv_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StAbs,
        StNorm,
        StRound,
        StPack,
        StHold
    } state_e;

    localparam logic RND_TRUNC = 1'b0;
    localparam logic RND_RNE   = 1'b1;

    function automatic int unsigned exp_bias(input int unsigned exp_w);
        return (32'd1 << (exp_w - 1)) - 32'd1;
    endfunction

    // Width of the leading-zero counter.
    function automatic int unsigned cnt_width(input int unsigned in_w);
        return $clog2(in_w) + 1;
    endfunction

    // Width of the working exponent; wide enough that e + BIAS + carry never wraps.
    function automatic int unsigned exp_calc_width(input int unsigned in_w,
                                                   input int unsigned exp_w);
        return exp_w + $clog2(in_w) + 2;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Combinational rounding, exponent carry, overflow saturation and field packing
// for a normalised magnitude (MSB set); a magnitude with clear MSB packs to +0.
module fp_round_pack
    import float_conv_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                         sign,
    input  logic [IN_W-1:0]              mag,
    input  logic [cnt_width(IN_W)-1:0]   k,
    input  logic                         rnd_mode,
    output logic [EXP_W+MAN_W:0]         result,
    output logic                         overflow,
    output logic                         inexact
);

    localparam int unsigned FW    = IN_W - 1;
    localparam int unsigned XW    = FW + MAN_W + 2;
    localparam int unsigned EW    = exp_calc_width(IN_W, EXP_W);
    localparam int unsigned BIAS  = exp_bias(EXP_W);
    localparam int unsigned MAX_E = (32'd1 << EXP_W) - 32'd1;

    logic [XW-1:0]    ext;
    logic [MAN_W-1:0] frac;
    logic             guard;
    logic             sticky;
    logic             round_up;
    logic [MAN_W:0]   frac_inc;
    logic [EW-1:0]    exp_b;

    always_comb begin
        // Zero padding keeps G/S well defined when MAN_W >= IN_W-1.
        ext      = {mag[IN_W-2:0], {(MAN_W + 2){1'b0}}};
        frac     = ext[XW-1 -: MAN_W];
        guard    = ext[XW-1-MAN_W];
        sticky   = |ext[XW-2-MAN_W:0];
        round_up = (rnd_mode == RND_RNE) && guard && (sticky || frac[0]);
        frac_inc = {1'b0, frac} + {{MAN_W{1'b0}}, round_up};
        exp_b    = EW'(IN_W - 1) - EW'(k) + EW'(BIAS) + EW'(frac_inc[MAN_W]);
        overflow = 1'b0;
        inexact  = 1'b0;
        result   = '0;
        if (mag[IN_W-1]) begin
            if (exp_b >= EW'(MAX_E)) begin
                overflow = 1'b1;
                inexact  = 1'b1;
                result   = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            end else begin
                inexact  = guard | sticky;
                result   = {sign, exp_b[EXP_W-1:0], frac_inc[MAN_W-1:0]};
            end
        end
    end

endmodule

// File: rtl/int_to_float_conv.sv
// Multi-cycle integer to binary-float converter with signed/unsigned select,
// truncate/RNE rounding and valid/ready handshakes; one conversion in flight.
module int_to_float_conv
    import float_conv_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned EXP_W = 5,
    parameter int unsigned MAN_W = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_data,
    input  logic                 in_signed,
    input  logic                 rnd_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_data,
    output logic                 out_overflow,
    output logic                 out_inexact
);

    localparam int unsigned KW    = cnt_width(IN_W);
    localparam int unsigned OUT_W = 1 + EXP_W + MAN_W;

    state_e            state_q, state_d;
    logic [IN_W-1:0]   data_q;
    logic              signed_q;
    logic              rnd_q;
    logic              sign_q;
    logic [IN_W-1:0]   mag_q;
    logic [KW-1:0]     k_q;
    logic [OUT_W-1:0]  res_data_q;
    logic              res_ovf_q;
    logic              res_inx_q;

    logic              sign_abs;
    logic [IN_W-1:0]   mag_abs;
    logic [OUT_W-1:0]  rp_data;
    logic              rp_ovf;
    logic              rp_inx;

    assign in_ready = (state_q == StIdle);

    // Most-negative input negates to 2^(IN_W-1), which is the right unsigned magnitude.
    always_comb begin
        sign_abs = signed_q & data_q[IN_W-1];
        mag_abs  = sign_abs ? (~data_q + IN_W'(1)) : data_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (in_valid) state_d = StAbs;
            StAbs:   state_d = (mag_abs == '0) ? StPack : StNorm;
            StNorm:  if (mag_q[IN_W-1]) state_d = StRound;
            StRound: state_d = StPack;
            StPack:  state_d = StHold;
            StHold:  if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    fp_round_pack #(
        .IN_W  (IN_W),
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_pack (
        .sign     (sign_q),
        .mag      (mag_q),
        .k        (k_q),
        .rnd_mode (rnd_q),
        .result   (rp_data),
        .overflow (rp_ovf),
        .inexact  (rp_inx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q       <= '0;
            signed_q     <= 1'b0;
            rnd_q        <= 1'b0;
            sign_q       <= 1'b0;
            mag_q        <= '0;
            k_q          <= '0;
            res_data_q   <= '0;
            res_ovf_q    <= 1'b0;
            res_inx_q    <= 1'b0;
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        signed_q <= in_signed;
                        rnd_q    <= rnd_mode;
                    end
                end
                StAbs: begin
                    sign_q <= sign_abs;
                    mag_q  <= mag_abs;
                    k_q    <= '0;
                    if (mag_abs == '0) begin
                        res_data_q <= '0;
                        res_ovf_q  <= 1'b0;
                        res_inx_q  <= 1'b0;
                    end
                end
                StNorm: begin
                    if (!mag_q[IN_W-1]) begin
                        mag_q <= mag_q << 1;
                        k_q   <= k_q + KW'(1);
                    end
                end
                StRound: begin
                    res_data_q <= rp_data;
                    res_ovf_q  <= rp_ovf;
                    res_inx_q  <= rp_inx;
                end
                StPack: begin
                    out_data     <= res_data_q;
                    out_overflow <= res_ovf_q;
                    out_inexact  <= res_inx_q;
                    out_valid    <= 1'b1;
                end
                StHold: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float_conv.sv
// Directed self-checking bench for int_to_float_conv at IN_W=16, EXP_W=5, MAN_W=10.
module tb_int_to_float_conv;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_signed;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_overflow;
    logic        out_inexact;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    int_to_float_conv #(
        .IN_W  (16),
        .EXP_W (5),
        .MAN_W (10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_signed    (in_signed),
        .rnd_mode     (rnd_mode),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_overflow (out_overflow),
        .out_inexact  (out_inexact)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [15:0] d, input logic sg, input logic rm);
        int w;
        w = 0;
        while (!in_ready && w < 50) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("in_ready_idle", in_ready, 1);
        @(negedge clk);
        in_data   = d;
        in_signed = sg;
        rnd_mode  = rm;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("in_ready_drop", in_ready, 0);
    endtask

    task automatic convert(input string tag, input logic [15:0] d, input logic sg,
                           input logic rm, input logic [15:0] exp_d, input logic exp_o,
                           input logic exp_i, input int exp_lat, input int hold);
        int lat;
        start(d, sg, rm);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid && lat < 60);
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_data"}, out_data, exp_d);
        chk({tag, "_overflow"}, out_overflow, exp_o);
        chk({tag, "_inexact"}, out_inexact, exp_i);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, "_hold_valid"}, out_valid, 1);
            chk({tag, "_hold_data"}, out_data, exp_d);
            chk({tag, "_hold_in_ready"}, in_ready, 0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_release_valid"}, out_valid, 0);
        chk({tag, "_release_in_ready"}, in_ready, 1);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_signed = 1'b0;
        rnd_mode  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 16'h0000);
        chk("reset_overflow", out_overflow, 0);
        chk("reset_inexact", out_inexact, 0);
        @(negedge clk);
        reset = 1'b0;

        //        tag          data      sg    rm    expect    ovf   inx   lat hold
        convert("one_u",     16'h0001, 1'b0, 1'b1, 16'h3C00, 1'b0, 1'b0, 19, 0);
        convert("neg1_s",    16'hFFFF, 1'b1, 1'b1, 16'hBC00, 1'b0, 1'b0, 19, 0);
        convert("minneg_s",  16'h8000, 1'b1, 1'b1, 16'hF800, 1'b0, 1'b0, 4,  3);
        convert("2049_rne",  16'd2049, 1'b0, 1'b1, 16'h6800, 1'b0, 1'b1, 8,  0);
        convert("2051_rne",  16'd2051, 1'b0, 1'b1, 16'h6802, 1'b0, 1'b1, 8,  0);
        convert("2051_trn",  16'd2051, 1'b0, 1'b0, 16'h6801, 1'b0, 1'b1, 8,  0);
        convert("ffff_rne",  16'hFFFF, 1'b0, 1'b1, 16'h7C00, 1'b1, 1'b1, 4,  0);
        convert("ffff_trn",  16'hFFFF, 1'b0, 1'b0, 16'h7BFF, 1'b0, 1'b1, 4,  0);
        convert("2051_s",    16'd2051, 1'b1, 1'b1, 16'h6802, 1'b0, 1'b1, 8,  0);
        convert("m2051_s",   16'hF7FD, 1'b1, 1'b0, 16'hE801, 1'b0, 1'b1, 8,  0);
        convert("zero",      16'h0000, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0, 2,  10);
        convert("seven_u",   16'h0007, 1'b0, 1'b0, 16'h4700, 1'b0, 1'b0, 17, 0);

        // Asynchronous reset while the normaliser is shifting.
        start(16'h0001, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("midnorm_out_valid", out_valid, 0);
        chk("midnorm_in_ready", in_ready, 1);
        chk("midnorm_out_data", out_data, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        convert("post_reset", 16'd2051, 1'b0, 1'b1, 16'h6802, 1'b0, 1'b1, 8, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
